imem_fetch_hazard: RTL and testbench

Parametrised instruction memory with integrated load-use hazard interlock for the pipelined RV32I core. Sits between the PC register and the IF/ID boundary: reads the instruction word addressed by the PC, detects load-use dependencies against the instruction currently issued to decode, holds the PC and inserts a configurable number of bubbles, and squashes fetch on a taken-branch redirect. Generalises the single-bubble, fixed-depth fetch/stall logic to configurable depth, bubble count, full source-operand decoding and flush.

---
 rtl/imem_fetch_hazard.sv | 157 +++++++++++++++
 tb/tb_imem_fetch_hazard.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_hazard.sv
// imem_fetch_hazard: instruction memory with load-use hazard interlock and fetch flush.
// Reads the word addressed by pc_i each cycle and issues it to decode one cycle later.
// Holds the PC and inserts LOAD_BUBBLES NOPs when the fetched word reads the register
// written by the load currently in decode.
// Optional feature macro: IMEM_FETCH_FLUSH_EN. When it is defined, flush_i squashes
// the current fetch. When it is undefined, flush_i is present but ignored.
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   pc_i       fetch address
//   flush_i    taken-branch redirect from EX
//   inst_o     registered instruction issued to decode
//   pc_en_o    combinational PC write enable (0 = hold PC)
//   stall_o    combinational, 1 when this cycle issues a hazard bubble
//   misalign_o registered, 1 when the issued slot came from a misaligned pc_i
module imem_fetch_hazard #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH_LOG2   = 18,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter              INIT_FILE    = "imem.hex"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] inst_o,
  output logic            pc_en_o,
  output logic            stall_o,
  output logic            misalign_o
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [1:0]  BUBBLES = 2'(LOAD_BUBBLES);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0033);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {RUN, STALL} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] inst_d;
  logic            misalign_d;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] fetch;
  logic            use_rs1, use_rs2;
  logic            load_in_dec, hazard, misaligned, flush_act;

  // Asynchronous read. Upper PC bits are dropped, so the address wraps.
  assign fetch = mem[pc_i[DEPTH_LOG2+1:2]];

`ifdef IMEM_FETCH_FLUSH_EN
  assign flush_act = flush_i;
  logic unused_bits;
  assign unused_bits = ^pc_i[XLEN-1:DEPTH_LOG2+2];
`else
  assign flush_act = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{pc_i[XLEN-1:DEPTH_LOG2+2], flush_i};
`endif

  assign misaligned  = pc_i[1:0] != 2'b00;
  assign load_in_dec = (inst_o[6:0] == OP_LOAD) && (inst_o[11:7] != 5'd0);

  // Determine which source operands the fetched word reads.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (fetch[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = load_in_dec &&
                  ((use_rs1 && (fetch[19:15] == inst_o[11:7])) ||
                   (use_rs2 && (fetch[24:20] == inst_o[11:7])));

  // State, bubble counter and issue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 2'd0;
      inst_o     <= NOP;
      misalign_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_o     <= inst_d;
      misalign_o <= misalign_d;
    end
  end

  // Next state. Flush and misalignment both cancel any pending stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_act || misaligned) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            state_d = STALL;
            cnt_d   = 2'd1;
          end
        end
        STALL: begin
          if (cnt_q < BUBBLES) begin
            cnt_d = cnt_q + 2'd1;
          end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs. The load has left decode by STALL, so no hazard re-check is needed there.
  always_comb begin
    pc_en_o    = 1'b1;
    stall_o    = 1'b0;
    inst_d     = fetch;
    misalign_d = 1'b0;
    if (rst) begin
      pc_en_o = 1'b0;
      inst_d  = NOP;
    end else if (flush_act) begin
      inst_d = NOP;
    end else if (misaligned) begin
      inst_d     = NOP;
      misalign_d = 1'b1;
    end else if ((state_q == RUN && hazard) ||
                 (state_q == STALL && cnt_q < BUBBLES)) begin
      pc_en_o = 1'b0;
      stall_o = 1'b1;
      inst_d  = NOP;
    end
  end

endmodule

// File: tb/tb_imem_fetch_hazard.sv
// Scoreboard bench for imem_fetch_hazard. It uses two instances, one with
// LOAD_BUBBLES=1 (sel 0) and one with LOAD_BUBBLES=3 (sel 1).
module tb_imem_fetch_hazard;

  localparam logic [31:0] NOP   = 32'h0000_0033;
  localparam logic [31:0] LW5   = 32'h0000_A283;
  localparam logic [31:0] ADD   = 32'h0022_8333;
  localparam logic [31:0] LW0   = 32'h0000_A003;
  localparam logic [31:0] SW5   = 32'h0051_A023;
  localparam logic [31:0] LUI5  = 32'h0000_52B7;
  localparam logic [31:0] LW55  = 32'h0002_A283;
  localparam logic [31:0] ADDI0 = 32'h0000_0013;

  logic        clk, rst, flush;
  logic [31:0] pc;
  logic [31:0] inst1, inst3;
  logic        pc_en1, pc_en3, stall1, stall3, mis1, mis3;

  typedef struct {
    logic        sel;
    int          id;
    logic        pc_en;
    logic        stall;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   step_no = 0;

  imem_fetch_hazard #(.XLEN(32), .DEPTH_LOG2(4), .LOAD_BUBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .pc_i(pc), .flush_i(flush),
    .inst_o(inst1), .pc_en_o(pc_en1), .stall_o(stall1), .misalign_o(mis1)
  );

  imem_fetch_hazard #(.XLEN(32), .DEPTH_LOG2(4), .LOAD_BUBBLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .pc_i(pc), .flush_i(flush),
    .inst_o(inst3), .pc_en_o(pc_en3), .stall_o(stall3), .misalign_o(mis3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp_v);
    cmp_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and queue what the selected instance must show.
  task automatic step(input logic sel, input logic [31:0] p, input logic f,
                      input logic r, input logic e_en, input logic e_st,
                      input logic [31:0] e_inst, input logic e_mis);
    exp_t e;
    pc    = p;
    flush = f;
    rst   = r;
    e.sel   = sel;
    e.id    = step_no;
    e.pc_en = e_en;
    e.stall = e_st;
    e.inst  = e_inst;
    e.mis   = e_mis;
    step_no++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: combinational outputs are checked mid-cycle, registered ones after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_en", e.id, 32'(e.sel ? pc_en3 : pc_en1), 32'(e.pc_en));
        chk("stall", e.id, 32'(e.sel ? stall3 : stall1), 32'(e.stall));
        @(posedge clk);
        #1;
        chk("inst", e.id, e.sel ? inst3 : inst1, e.inst);
        chk("misalign", e.id, 32'(e.sel ? mis3 : mis1), 32'(e.mis));
      end
    end
  end

  initial begin : stim
    logic [31:0] prog [12];
    rst = 1'b1; pc = '0; flush = 1'b0;
    prog[0] = LW5;  prog[1] = ADD;  prog[2]  = LW0;  prog[3]  = ADD;
    prog[4] = LW5;  prog[5] = SW5;  prog[6]  = LW5;  prog[7]  = LUI5;
    prog[8] = LW5;  prog[9] = ADD;  prog[10] = LW55; prog[11] = ADD;
    #1;
    for (int i = 0; i < 16; i++) begin
      u_dut1.mem[i] = (i < 12) ? prog[i] : ADDI0;
      u_dut3.mem[i] = (i < 12) ? prog[i] : ADDI0;
    end
    @(posedge clk);
    #1;

    // LOAD_BUBBLES = 1
    step(0, 0,  0, 1, 0, 0, NOP,  0);
    step(0, 0,  0, 1, 0, 0, NOP,  0);
    step(0, 0,  0, 0, 1, 0, LW5,  0);
    step(0, 4,  0, 0, 0, 1, NOP,  0);
    step(0, 4,  0, 0, 1, 0, ADD,  0);
    step(0, 8,  0, 0, 1, 0, LW0,  0);
    step(0, 12, 0, 0, 1, 0, ADD,  0);
    step(0, 16, 0, 0, 1, 0, LW5,  0);
    step(0, 20, 0, 0, 0, 1, NOP,  0);
    step(0, 20, 0, 0, 1, 0, SW5,  0);
    step(0, 24, 0, 0, 1, 0, LW5,  0);
    step(0, 28, 0, 0, 1, 0, LUI5, 0);
    step(0, 6,  0, 0, 1, 0, NOP,  1);
    step(0, 32, 0, 0, 1, 0, LW5,  0);
    step(0, 40, 0, 0, 0, 1, NOP,  0);
    step(0, 40, 0, 0, 1, 0, LW55, 0);
    step(0, 44, 0, 0, 0, 1, NOP,  0);
    step(0, 44, 0, 0, 1, 0, ADD,  0);

    // LOAD_BUBBLES = 3
    step(1, 0,  0, 1, 0, 0, NOP,  0);
    step(1, 0,  0, 0, 1, 0, LW5,  0);
    step(1, 4,  0, 0, 0, 1, NOP,  0);
    step(1, 4,  0, 1, 0, 0, NOP,  0);
    step(1, 4,  0, 0, 1, 0, ADD,  0);
    step(1, 0,  0, 0, 1, 0, LW5,  0);
    step(1, 4,  0, 0, 0, 1, NOP,  0);
    step(1, 4,  0, 0, 0, 1, NOP,  0);
    step(1, 4,  0, 0, 0, 1, NOP,  0);
    step(1, 4,  0, 0, 1, 0, ADD,  0);
    step(1, 8,  0, 0, 1, 0, LW0,  0);
    step(1, 12, 0, 0, 1, 0, ADD,  0);
    step(1, 16, 0, 0, 1, 0, LW5,  0);
    step(1, 20, 0, 0, 0, 1, NOP,  0);
`ifdef IMEM_FETCH_FLUSH_EN
    step(1, 20, 1, 0, 1, 0, NOP,  0);
    step(1, 24, 0, 0, 1, 0, LW5,  0);
    step(1, 36, 1, 0, 1, 0, NOP,  0);
    step(1, 40, 0, 0, 1, 0, LW55, 0);
`else
    step(1, 20, 1, 0, 0, 1, NOP,  0);
    step(1, 20, 0, 0, 0, 1, NOP,  0);
    step(1, 20, 0, 0, 1, 0, SW5,  0);
    step(1, 24, 0, 0, 1, 0, LW5,  0);
    step(1, 36, 1, 0, 0, 1, NOP,  0);
    step(1, 36, 0, 0, 0, 1, NOP,  0);
    step(1, 36, 0, 0, 0, 1, NOP,  0);
    step(1, 36, 0, 0, 1, 0, ADD,  0);
`endif

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
